fma16_issue: RTL and testbench
==============================

Name: fma16_issue

Overview:
Upstream issue stage for the half-precision FMA datapath. It accepts FP operation requests over a valid/ready handshake and decodes the op code into the mul/add/negp/negz controls. Requests are buffered in a small FIFO. The head entry is presented, fully decoded and registered, to the combinational fma16 core, so the core's inputs always come from flops.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
TAGW, 4, width of the opaque request tag carried alongside each operation

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-high reset
flush  input  1  synchronous flush; discards all buffered entries
in_valid  input  1  request valid
in_ready  output  1  request can be accepted
in_op  input  3  0 FMADD, 1 FMSUB, 2 FNMSUB, 3 FNMADD, 4 FMUL, 5 FADD, 6 FSUB, 7 illegal
in_rm  input  2  rounding mode, passed through unchanged
in_x  input  16  operand x
in_y  input  16  operand y
in_z  input  16  operand z
in_tag  input  TAGW  request tag
out_valid  output  1  head entry valid toward fma16
out_ready  input  1  consumer accepts head entry
x  output  16  to fma16 x
y  output  16  to fma16 y
z  output  16  to fma16 z
mul  output  1  to fma16 mul
add  output  1  to fma16 add
negp  output  1  to fma16 negp
negz  output  1  to fma16 negz
roundmode  output  2  to fma16 roundmode
out_tag  output  TAGW  tag of head entry
count  output  $clog2(DEPTH)+1  current occupancy
illegal  output  1  one-cycle pulse: an op-7 request was accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset.
- Reset values:
  - count=0, read/write pointers=0, out_valid=0, illegal=0.
  - All storage entries cleared, so x/y/z/tag/controls/roundmode read 0 while empty after reset.
  - in_ready=1.
- Handshake:
  - Push when in_valid&&in_ready.
  - Pop when out_valid&&out_ready.
  - in_ready = (count<DEPTH). No same-cycle pass-through when full: a full FIFO with out_ready=1 still shows in_ready=0 that cycle.
- Decode, stored at enqueue:
  - op0: mul=1, add=1, negp=0, negz=0.
  - op1: negz=1.
  - op2: negp=1.
  - op3: negp=1, negz=1.
  - op4: mul=1, add=0; z stored as 16'h0000.
  - op5: mul=0, add=1; y stored as 16'h3C00.
  - op6: as op5 plus negz=1.
  - op7: handshake completes, nothing is enqueued, count is unchanged, and illegal=1 the following cycle only.
- Data path:
  - Outputs x, y, z, controls, roundmode and out_tag come directly from the head storage entry; no combinational path from in_* to outputs.
  - out_valid = (count!=0).
  - Latency: a request accepted at edge N is visible with out_valid=1 after edge N when the FIFO was empty.
- Output stability: while out_valid=1 and out_ready=0, every output stays stable.
- Order: strict FIFO; pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance. Legal when 0<count<DEPTH. When count=0, no pop occurs.
- flush:
  - Next edge: count=0, pointers=0, out_valid=0.
  - Takes priority over a same-cycle push and pop. The push is dropped, but still counts as handshaken if in_ready was 1.
  - illegal is still pulsed for an op-7 request in the flush cycle.
  - Storage contents need not be cleared by flush.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are lost.

Test Plan:
1. Reset, then push op0 with x=3C00, y=4000, z=4200, rm=0, tag=5 while out_ready=0 -> next cycle out_valid=1, mul=1, add=1, negp=0, negz=0, operands and tag=5 hold stable for 3 cycles; raise out_ready -> pop, count=0.
2. Push op4 with z=4200, then op5 with y=4000, then op6 -> head sequence:
   - op4: z=0000, add=0.
   - op5: y=3C00, mul=0.
   - op6: negz=1.
3. Push 4 requests with out_ready=0 -> count=4, in_ready=0. Then with in_valid=1 and out_ready=1 -> same cycle in_ready=0; next cycle in_ready=1, count=3.
4. Streaming: hold in_valid=1 and out_ready=1 for 10 tags 0..9 with count=1 -> count stays 1, all tags emerge in order, pointer wrap verified.
5. Push op7 -> in_ready=1, count unchanged, illegal pulses exactly 1 cycle.
6. count=3, then assert flush together with a push -> next cycle count=0, out_valid=0. Also assert reset mid-stream -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fma16_issue.sv
// ============================================================================
// Module   : fma16_issue
// Purpose  : Issue FIFO for the half-precision FMA core. It decodes each
//            request into mul/add/negp/negz controls on the way in, so the
//            core always sees a registered head entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fma16_issue #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [1:0]               in_rm,
  input  logic [15:0]              in_x,
  input  logic [15:0]              in_y,
  input  logic [15:0]              in_z,
  input  logic [TAGW-1:0]          in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              x,
  output logic [15:0]              y,
  output logic [15:0]              z,
  output logic                     mul,
  output logic                     add,
  output logic                     negp,
  output logic                     negz,
  output logic [1:0]               roundmode,
  output logic [TAGW-1:0]          out_tag,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] OP_FMADD  = 3'd0;
  localparam logic [2:0] OP_FMSUB  = 3'd1;
  localparam logic [2:0] OP_FNMSUB = 3'd2;
  localparam logic [2:0] OP_FNMADD = 3'd3;
  localparam logic [2:0] OP_FMUL   = 3'd4;
  localparam logic [2:0] OP_FADD   = 3'd5;
  localparam logic [2:0] OP_FSUB   = 3'd6;
  localparam logic [2:0] OP_ILL    = 3'd7;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

  typedef struct packed {
    logic [15:0]     x;
    logic [15:0]     y;
    logic [15:0]     z;
    logic            mul;
    logic            add;
    logic            negp;
    logic            negz;
    logic [1:0]      rm;
    logic [TAGW-1:0] tag;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            push;
  logic            pop;
  logic            illegal_q;

  assign in_ready  = (cnt < FULL);
  assign out_valid = (cnt != '0);
  assign accept    = in_valid && in_ready;
  // An illegal op completes the handshake but never occupies a slot.
  assign push      = accept && (in_op != OP_ILL) && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    dec.x    = in_x;
    dec.y    = in_y;
    dec.z    = in_z;
    dec.mul  = 1'b1;
    dec.add  = 1'b1;
    dec.negp = 1'b0;
    dec.negz = 1'b0;
    dec.rm   = in_rm;
    dec.tag  = in_tag;
    case (in_op)
      OP_FMADD:  ;
      OP_FMSUB:  dec.negz = 1'b1;
      OP_FNMSUB: dec.negp = 1'b1;
      OP_FNMADD: begin
        dec.negp = 1'b1;
        dec.negz = 1'b1;
      end
      OP_FMUL: begin
        dec.add = 1'b0;
        dec.z   = FP16_ZERO;
      end
      // Plain add/sub run through the multiplier as x * 1.0 + z.
      OP_FADD: begin
        dec.mul = 1'b0;
        dec.y   = FP16_ONE;
      end
      OP_FSUB: begin
        dec.mul  = 1'b0;
        dec.y    = FP16_ONE;
        dec.negz = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr] <= dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && (in_op == OP_ILL);
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + 1'b1;
        end
        if (pop) begin
          rptr <= rptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign head      = mem[rptr];
  assign x         = head.x;
  assign y         = head.y;
  assign z         = head.z;
  assign mul       = head.mul;
  assign add       = head.add;
  assign negp      = head.negp;
  assign negz      = head.negz;
  assign roundmode = head.rm;
  assign out_tag   = head.tag;
  assign count     = cnt;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_fma16_issue.sv
// ============================================================================
// Module   : tb_fma16_issue
// Purpose  : Directed scoreboard bench for the fma16_issue FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fma16_issue;

  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
  localparam int EW    = 48 + 4 + 2 + TAGW;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [1:0]      in_rm;
  logic [15:0]     in_x;
  logic [15:0]     in_y;
  logic [15:0]     in_z;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     x;
  logic [15:0]     y;
  logic [15:0]     z;
  logic            mul;
  logic            add;
  logic            negp;
  logic            negz;
  logic [1:0]      roundmode;
  logic [TAGW-1:0] out_tag;
  logic [2:0]      count;
  logic            illegal;

  logic [EW-1:0]   head_vec;
  logic [EW-1:0]   sb [$];
  logic [EW-1:0]   exp_head;
  int              passed;
  int              total;

  fma16_issue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rm(in_rm),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .y(y), .z(z), .mul(mul), .add(add), .negp(negp), .negz(negz),
    .roundmode(roundmode), .out_tag(out_tag), .count(count), .illegal(illegal)
  );

  assign head_vec = {x, y, z, mul, add, negp, negz, roundmode, out_tag};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic logic [EW-1:0] model(input logic [2:0] op, input logic [1:0] rm,
                                          input logic [15:0] ax, input logic [15:0] ay,
                                          input logic [15:0] az, input logic [TAGW-1:0] t);
    logic m, a, np, nz;
    logic [15:0] yy, zz;
    m = 1'b1; a = 1'b1; np = 1'b0; nz = 1'b0; yy = ay; zz = az;
    case (op)
      3'd1: nz = 1'b1;
      3'd2: np = 1'b1;
      3'd3: begin np = 1'b1; nz = 1'b1; end
      3'd4: begin a = 1'b0; zz = 16'h0000; end
      3'd5: begin m = 1'b0; yy = 16'h3C00; end
      3'd6: begin m = 1'b0; yy = 16'h3C00; nz = 1'b1; end
      default: ;
    endcase
    return {ax, yy, zz, m, a, np, nz, rm, t};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [1:0] rm, input logic [15:0] ax,
                       input logic [15:0] ay, input logic [15:0] az, input logic [TAGW-1:0] t);
    in_valid = 1'b1; in_op = op; in_rm = rm;
    in_x = ax; in_y = ay; in_z = az; in_tag = t;
  endtask

  // Predict the handshakes of the coming edge, then advance to 1 ns after it.
  task automatic step();
    if (!flush && out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_head = sb.pop_front();
        check("head", 64'(head_vec), 64'(exp_head));
      end
    end
    if (!flush && in_valid && in_ready && in_op != 3'd7)
      sb.push_back(model(in_op, in_rm, in_x, in_y, in_z, in_tag));
    if (flush) sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!out_valid && sb.size() == 0) break;
      step();
    end
    check("drain_count", 64'(count), 64'd0);
    check("drain_sb", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    passed = 0; total = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rm = '0; in_x = '0; in_y = '0; in_z = '0; in_tag = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_illegal", 64'(illegal), 64'd0);
    check("rst_head", 64'(head_vec), 64'd0);

    // 1: op0 held at the head while the consumer stalls
    drive(3'd0, 2'd0, 16'h3C00, 16'h4000, 16'h4200, 4'd5);
    step();
    in_valid = 1'b0;
    check("t1_out_valid", 64'(out_valid), 64'd1);
    check("t1_ctl", 64'({mul, add, negp, negz}), 64'b1100);
    for (int i = 0; i < 3; i++) begin
      check("t1_stable", 64'(head_vec), 64'(model(3'd0, 2'd0, 16'h3C00, 16'h4000, 16'h4200, 4'd5)));
      step();
    end
    out_ready = 1'b1;
    step();
    check("t1_count", 64'(count), 64'd0);
    check("t1_empty", 64'(out_valid), 64'd0);

    // 2: FMUL / FADD / FSUB operand substitution
    out_ready = 1'b0;
    drive(3'd4, 2'd1, 16'h4400, 16'h4000, 16'h4200, 4'd1); step();
    check("t2_fmul_z", 64'(z), 64'h0000);
    check("t2_fmul_add", 64'(add), 64'd0);
    drive(3'd5, 2'd2, 16'h4500, 16'h4000, 16'h4100, 4'd2); step();
    drive(3'd6, 2'd3, 16'h4600, 16'h4800, 16'h4900, 4'd3); step();
    drive(3'd2, 2'd0, 16'h1234, 16'h5678, 16'h9ABC, 4'd4); step();
    check("t2_full", 64'(in_ready), 64'd0);
    drain();

    // 3: full FIFO with a waiting producer and a ready consumer
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'(i), 2'(i), 16'(16'h1000 + i), 16'(16'h2000 + i), 16'(16'h3000 + i), 4'(8 + i));
      step();
    end
    check("t3_count4", 64'(count), 64'd4);
    check("t3_not_ready", 64'(in_ready), 64'd0);
    drive(3'd3, 2'd1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 4'd15);
    out_ready = 1'b1;
    check("t3_same_cycle_ready", 64'(in_ready), 64'd0);
    step();
    check("t3_ready_after", 64'(in_ready), 64'd1);
    check("t3_count3", 64'(count), 64'd3);
    drain();

    // 4: streaming at occupancy one, pointers wrap repeatedly
    out_ready = 1'b0;
    drive(3'd0, 2'd0, 16'h0100, 16'h0200, 16'h0300, 4'd0);
    step();
    out_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      drive(3'(i % 7), 2'(i), 16'(i), 16'(i * 3), 16'(i * 5), 4'(i));
      step();
      check("t4_count1", 64'(count), 64'd1);
    end
    drain();

    // 5: illegal op handshakes but is not enqueued
    out_ready = 1'b0;
    drive(3'd1, 2'd0, 16'h0001, 16'h0002, 16'h0003, 4'd6); step();
    drive(3'd7, 2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'd7);
    check("t5_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("t5_count", 64'(count), 64'd1);
    check("t5_illegal_hi", 64'(illegal), 64'd1);
    step();
    check("t5_illegal_lo", 64'(illegal), 64'd0);
    drain();

    // 6: flush beats a simultaneous push and pop, then asynchronous reset
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(3'd0, 2'd0, 16'(i), 16'(i), 16'(i), 4'(i)); step();
    end
    check("t6_count3", 64'(count), 64'd3);
    drive(3'd7, 2'd0, 16'h7777, 16'h7777, 16'h7777, 4'd7);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t6_flush_count", 64'(count), 64'd0);
    check("t6_flush_valid", 64'(out_valid), 64'd0);
    check("t6_flush_illegal", 64'(illegal), 64'd1);
    out_ready = 1'b0;
    drive(3'd5, 2'd0, 16'h4000, 16'h0000, 16'h4000, 4'd9); step();
    drive(3'd4, 2'd0, 16'h4000, 16'h4000, 16'h4000, 4'd10); step();
    in_valid = 1'b0;
    check("t6_pre_reset", 64'(count), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", 64'(out_valid), 64'd0);
    check("t6_async_count", 64'(count), 64'd0);
    check("t6_async_head", 64'(head_vec), 64'd0);
    sb.delete();
    #1;
    reset = 1'b0;
    step();
    check("t6_post_ready", 64'(in_ready), 64'd1);
    drive(3'd0, 2'd2, 16'h3C00, 16'h3C00, 16'h3C00, 4'd3); step();
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
